// File: rtl/serialtopara_pkg.sv
// Shared constants for the two-lane serial-to-parallel receiver.
package serialtopara_pkg;

  // Number of independent serial lanes handled by the top level.
  localparam int unsigned NUM_LANES = 2;

  // Idle / alignment symbol sent by the transmitter whenever it has no data.
  localparam logic [7:0] COMMA = 8'hBC;

  // Consecutive byte-aligned commas needed before a lane is declared active.
  localparam int unsigned ALIGN_COUNT = 4;

  // Width of the aligned-comma counter (ALIGN_COUNT is limited to 1..15).
  localparam int unsigned CCNT_W = 4;

  // Lane FSM encodings.
  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] LOCK   = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  // True when the bit counter marks the last bit of a byte.
  function automatic logic is_boundary(input logic [2:0] bitcnt);
    return bitcnt == 3'd7;
  endfunction

endpackage

// File: rtl/serialtopara_lane.sv
// One receive lane: comma search, byte lock, then byte-wide output every
// eight clocks. Lanes share nothing, so the top just replicates this.
module serialtopara_lane
  import serialtopara_pkg::*;
#(
  parameter logic [7:0]  COMMA_SYM = COMMA,
  parameter int unsigned ALIGN_CNT = ALIGN_COUNT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic [7:0] out,
  output logic       valid,
  output logic       active
);

  localparam logic [CCNT_W-1:0] ALIGN_W = CCNT_W'(ALIGN_CNT);

  // Only the 7 older bits need storing: the newest bit is 'in' itself, and
  // the bit that falls out of the 8-bit window is never looked at again.
  logic [6:0]        sr_q,       sr_d;
  logic [2:0]        bitcnt_q,   bitcnt_d;
  logic [CCNT_W-1:0] commacnt_q, commacnt_d;
  logic [1:0]        state_q,    state_d;
  logic [7:0]        out_q,      out_d;
  logic              valid_q,    valid_d;
  logic              active_q,   active_d;

  logic [7:0]        win;
  logic              comma_hit;
  logic              boundary;

  assign win       = {sr_q, in};
  assign comma_hit = (win == COMMA_SYM);
  assign boundary  = is_boundary(bitcnt_q);
  assign sr_d      = win[6:0];

  // Next-state logic for alignment and byte capture.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q + 3'd1;
    commacnt_d = commacnt_q;
    out_d      = out_q;
    valid_d    = valid_q;
    active_d   = active_q;
    case (state_q)
      SEARCH: begin
        // Bit-by-bit hunt; a hit defines the byte phase from here on.
        bitcnt_d = bitcnt_q;
        if (comma_hit) begin
          bitcnt_d   = 3'd0;
          commacnt_d = CCNT_W'(1);
          if (ALIGN_W == CCNT_W'(1)) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = LOCK;
          end
        end
      end
      LOCK: begin
        // Only whole bytes on the locked phase count; any non-comma byte
        // means the phase guess was wrong, so start over.
        if (boundary) begin
          if (comma_hit) begin
            commacnt_d = commacnt_q + CCNT_W'(1);
            if (commacnt_q + CCNT_W'(1) == ALIGN_W) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            state_d    = SEARCH;
            commacnt_d = '0;
          end
        end
      end
      ACTIVE: begin
        // Phase is fixed until reset; commas straddling bytes are ignored.
        if (boundary) begin
          out_d   = win;
          valid_d = !comma_hit;
        end
      end
      default: begin
        state_d    = SEARCH;
        bitcnt_d   = 3'd0;
        commacnt_d = '0;
      end
    endcase
  end

  // Register update with synchronous reset that aborts any alignment.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q       <= '0;
      bitcnt_q   <= '0;
      commacnt_q <= '0;
      state_q    <= SEARCH;
      out_q      <= 8'h00;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      bitcnt_q   <= bitcnt_d;
      commacnt_q <= commacnt_d;
      state_q    <= state_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      active_q   <= active_d;
    end
  end

  assign out    = out_q;
  assign valid  = valid_q;
  assign active = active_q;

endmodule

// File: rtl/serialtopara.sv
// Two-lane serial-to-parallel receiver: each lane is an independent
// comma-aligned 1:8 deserializer.
module serialtopara
  import serialtopara_pkg::*;
#(
  parameter logic [7:0]  COMMA_SYM = COMMA,
  parameter int unsigned ALIGN_CNT = ALIGN_COUNT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in0,
  input  logic       in1,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic       valid_0,
  output logic       valid_1,
  output logic       active_0,
  output logic       active_1
);

  logic [NUM_LANES-1:0]        lane_in;
  logic [NUM_LANES-1:0][7:0]   lane_out;
  logic [NUM_LANES-1:0]        lane_vld;
  logic [NUM_LANES-1:0]        lane_act;

  assign lane_in = {in1, in0};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    serialtopara_lane #(
      .COMMA_SYM (COMMA_SYM),
      .ALIGN_CNT (ALIGN_CNT)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .in     (lane_in[g]),
      .out    (lane_out[g]),
      .valid  (lane_vld[g]),
      .active (lane_act[g])
    );
  end

  assign out0     = lane_out[0];
  assign out1     = lane_out[1];
  assign valid_0  = lane_vld[0];
  assign valid_1  = lane_vld[1];
  assign active_0 = lane_act[0];
  assign active_1 = lane_act[1];

endmodule

// File: tb/tb_serialtopara.sv
// Scoreboard bench for serialtopara: a driver feeds per-lane bit queues,
// a reference model predicts every output each cycle, a monitor compares.
module tb_serialtopara;

  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam int         K_ALIGN = 4;

  logic       clk, reset, in0, in1;
  logic [7:0] out0, out1;
  logic       valid_0, valid_1, active_0, active_1;

  serialtopara dut (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1),
    .out0(out0), .out1(out1), .valid_0(valid_0), .valid_1(valid_1),
    .active_0(active_0), .active_1(active_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] o0, o1;
    logic       v0, v1, a0, a1;
  } exp_t;

  exp_t expq[$];
  bit   q0[$], q1[$];
  int   rst_req = 3;
  int   total = 0, bad = 0;

  // Reference model: byte phase is kept as an absolute sample index, and
  // byte boundaries are every 8th sample after the phase-defining comma.
  bit         hist [2][$];
  int         tcnt [2];
  int         lockp[2];
  int         ncom [2];
  bit         mact [2];
  logic [7:0] mout [2];
  bit         mval [2];

  function automatic void model_reset(int l);
    hist[l].delete();
    for (int k = 0; k < 8; k++) hist[l].push_back(1'b0);
    tcnt[l] = 0; lockp[l] = -1; ncom[l] = 0;
    mact[l] = 1'b0; mout[l] = 8'h00; mval[l] = 1'b0;
  endfunction

  function automatic void model_step(int l, bit b);
    logic [7:0] w;
    hist[l].push_back(b);
    void'(hist[l].pop_front());
    for (int k = 0; k < 8; k++) w[k] = hist[l][7-k];
    tcnt[l]++;
    if (lockp[l] < 0) begin
      if (w == K_COMMA) begin
        lockp[l] = tcnt[l]; ncom[l] = 1;
        if (K_ALIGN == 1) mact[l] = 1'b1;
      end
    end else if ((tcnt[l] - lockp[l]) % 8 == 0) begin
      if (mact[l]) begin
        mout[l] = w; mval[l] = (w != K_COMMA);
      end else if (w == K_COMMA) begin
        ncom[l]++;
        if (ncom[l] == K_ALIGN) mact[l] = 1'b1;
      end else begin
        lockp[l] = -1; ncom[l] = 0;
      end
    end
  endfunction

  task automatic check(string nm, logic [7:0] got, logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%02h exp=%02h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic push_bits(int l, logic [7:0] v, int n);
    for (int i = n - 1; i >= 0; i--)
      if (l == 0) q0.push_back(v[i]); else q1.push_back(v[i]);
  endtask

  task automatic push_byte(int l, logic [7:0] v);
    push_bits(l, v, 8);
  endtask

  function automatic logic [7:0] rnd_byte();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == K_COMMA) b = 8'h3C;
    return b;
  endfunction

  // Wait until the selected lane queues are empty; returns just after the
  // edge that sampled the last queued bit.
  task automatic drain(bit w0, bit w1);
    int n = 0;
    while (((w0 && q0.size() != 0) || (w1 && q1.size() != 0)) && n < 3000) begin
      @(posedge clk); n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL drain_timeout got=%0d exp=0", q0.size() + q1.size());
    end
    #2;
  endtask

  task automatic do_reset(int n);
    @(posedge clk); #2;
    rst_req = n;
    while (rst_req != 0) @(posedge clk);
    #2;
  endtask

  // Driver: one bit per lane per cycle, idle lanes send zeros.
  initial begin
    exp_t e;
    bit   b0, b1;
    reset = 1'b1; in0 = 1'b0; in1 = 1'b0;
    model_reset(0); model_reset(1);
    forever begin
      @(negedge clk);
      if (rst_req > 0) begin
        reset = 1'b1; in0 = 1'b0; in1 = 1'b0;
        rst_req--;
        q0.delete(); q1.delete();
        model_reset(0); model_reset(1);
      end else begin
        reset = 1'b0;
        b0 = 1'b0; b1 = 1'b0;
        if (q0.size() != 0) b0 = q0.pop_front();
        if (q1.size() != 0) b1 = q1.pop_front();
        in0 = b0; in1 = b1;
        model_step(0, b0); model_step(1, b1);
      end
      e.o0 = mout[0]; e.v0 = mval[0]; e.a0 = mact[0];
      e.o1 = mout[1]; e.v1 = mval[1]; e.a1 = mact[1];
      expq.push_back(e);
    end
  end

  // Monitor: every edge pops the prediction for that edge and compares.
  initial begin
    exp_t e;
    @(negedge clk);
    forever begin
      @(posedge clk); #1;
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty got=0 exp=1");
      end else begin
        e = expq.pop_front();
        check("sb_out0",    out0,     e.o0);
        check("sb_valid0",  8'(valid_0),  8'(e.v0));
        check("sb_active0", 8'(active_0), 8'(e.a0));
        check("sb_out1",    out1,     e.o1);
        check("sb_valid1",  8'(valid_1),  8'(e.v1));
        check("sb_active1", 8'(active_1), 8'(e.a1));
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic [7:0] last1;
    // 1: reset then idle zeros
    while (rst_req != 0) @(posedge clk);
    repeat (40) @(posedge clk);
    #2;
    check("t1_out0", out0, 8'h00);
    check("t1_valid0", 8'(valid_0), 8'h00);
    check("t1_active0", 8'(active_0), 8'h00);
    check("t1_active1", 8'(active_1), 8'h00);

    // 2: four commas, active exactly after the last comma bit
    repeat (3) push_byte(0, K_COMMA);
    push_bits(0, K_COMMA >> 1, 7);
    drain(1, 0);
    check("t2_active_early", 8'(active_0), 8'h00);
    check("t2_out_lock", out0, 8'h00);
    push_bits(0, K_COMMA, 1);
    drain(1, 0);
    check("t2_active", 8'(active_0), 8'h01);
    push_byte(0, 8'h5A);
    drain(1, 0);
    check("t2_out5A", out0, 8'h5A);
    check("t2_valid5A", 8'(valid_0), 8'h01);
    push_byte(0, 8'hFF);
    drain(1, 0);
    check("t2_outFF", out0, 8'hFF);
    check("t2_validFF", 8'(valid_0), 8'h01);

    // 3: misaligned start
    do_reset(2);
    check("t3_rst_active", 8'(active_0), 8'h00);
    push_bits(0, 8'($urandom), 3);
    repeat (4) push_byte(0, K_COMMA);
    drain(1, 0);
    check("t3_active", 8'(active_0), 8'h01);
    b = rnd_byte();
    push_byte(0, rnd_byte());
    push_byte(0, b);
    drain(1, 0);
    check("t3_out", out0, b);
    check("t3_valid", 8'(valid_0), 8'h01);

    // 4: broken comma run restarts the count
    do_reset(2);
    push_byte(0, K_COMMA); push_byte(0, K_COMMA); push_byte(0, 8'h3C);
    repeat (3) push_byte(0, K_COMMA);
    drain(1, 0);
    check("t4_not_yet", 8'(active_0), 8'h00);
    push_byte(0, K_COMMA);
    drain(1, 0);
    check("t4_active", 8'(active_0), 8'h01);

    // 5: lane 0 data/comma/data while lane 1 aligns 5 clks offset
    push_bits(1, 8'h00, 5);
    repeat (4) push_byte(1, K_COMMA);
    last1 = rnd_byte();
    push_byte(1, rnd_byte());
    push_byte(1, last1);
    push_byte(0, 8'h12);
    drain(1, 0);
    check("t5_out12", out0, 8'h12);
    check("t5_v12", 8'(valid_0), 8'h01);
    push_byte(0, K_COMMA);
    drain(1, 0);
    check("t5_outBC", out0, K_COMMA);
    check("t5_vBC", 8'(valid_0), 8'h00);
    push_byte(0, 8'h34);
    drain(1, 0);
    check("t5_out34", out0, 8'h34);
    check("t5_v34", 8'(valid_0), 8'h01);
    drain(0, 1);
    check("t5_active1", 8'(active_1), 8'h01);
    check("t5_out1", out1, last1);

    // random traffic on both active lanes, commas mixed in
    for (int i = 0; i < 40; i++) begin
      push_byte(0, ($urandom_range(0, 5) == 0) ? K_COMMA : 8'($urandom));
      push_byte(1, ($urandom_range(0, 5) == 0) ? K_COMMA : 8'($urandom));
    end
    drain(1, 1);

    // 6: reset mid-byte while active, then realign
    push_byte(0, rnd_byte()); push_byte(0, rnd_byte());
    repeat (11) @(posedge clk);
    #2;
    rst_req = 1;
    @(posedge clk); #2;
    check("t6_out", out0, 8'h00);
    check("t6_valid", 8'(valid_0), 8'h00);
    check("t6_active", 8'(active_0), 8'h00);
    check("t6_active1", 8'(active_1), 8'h00);
    repeat (3) push_byte(0, K_COMMA);
    drain(1, 0);
    check("t6_not_yet", 8'(active_0), 8'h00);
    push_byte(0, K_COMMA);
    b = rnd_byte();
    push_byte(0, b);
    drain(1, 0);
    check("t6_reactive", 8'(active_0), 8'h01);
    check("t6_out_after", out0, b);

    repeat (4) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
